// File: rtl/compare_sort_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : compare_sort_ctrl (with helper compare_sort_ctrl_cmp)
//  Purpose  : Frame sorter. Accepts DEPTH unsigned elements, bubble-sorts them
//             in place with a single shared comparator, counts adjacent equal
//             pairs in the sorted frame, then streams the frame out ascending.
//  Ports    : clk, rst (async, active-high)
//             in_valid / in_ready / in_data           - input stream
//             out_valid / out_ready / out_data / out_last - output stream
//             dup_count - adjacent equal pairs of the last sorted frame
//             busy      - high while sorting or counting duplicates
//  Revision : 1.0 - initial release
// ============================================================================

// Shared comparator: op=1 -> in_1 < in_0, op=0 -> in_1 == in_0.
module compare_sort_ctrl_cmp #(
  parameter int WIDTH = 4
) (
  input  logic             op_i,
  input  logic [WIDTH-1:0] in_0_i,
  input  logic [WIDTH-1:0] in_1_i,
  output logic             comp_out_o
);
  assign comp_out_o = op_i ? (in_1_i < in_0_i) : (in_1_i == in_0_i);
endmodule

module compare_sort_ctrl #(
  parameter int INPUT_SIZE = 4,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INPUT_SIZE-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INPUT_SIZE-1:0]    out_data,
  output logic                     out_last,
  output logic [$clog2(DEPTH)-1:0] dup_count,
  output logic                     busy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] c_LAST_IDX = PTR_W'(DEPTH - 2);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SORT  = 2'd1,
    ST_DUPS  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        idx_q, idx_d;
  logic [PTR_W-1:0]        pass_q, pass_d;     // completed sort passes
  logic                    swapped_q, swapped_d; // any swap in current pass
  logic [PTR_W-1:0]        dup_q, dup_d;
  logic [INPUT_SIZE-1:0]   mem_q [DEPTH];

  logic [PTR_W-1:0]        idx_nxt;
  logic                    cmp_op;
  logic                    cmp_out;
  logic                    load_wr;
  logic                    do_swap;

  assign idx_nxt = idx_q + PTR_W'(1);

  compare_sort_ctrl_cmp #(.WIDTH(INPUT_SIZE)) u_cmp (
    .op_i       (cmp_op),
    .in_0_i     (mem_q[idx_q]),
    .in_1_i     (mem_q[idx_nxt]),
    .comp_out_o (cmp_out)
  );

  // in_ready is gated by rst so nothing is accepted while reset is held.
  assign in_ready  = (state_q == ST_LOAD) && !rst;
  assign load_wr   = in_valid && in_ready;
  assign cmp_op    = (state_q == ST_SORT);
  assign do_swap   = (state_q == ST_SORT) && cmp_out;
  assign out_valid = (state_q == ST_DRAIN);
  assign out_data  = mem_q[rd_ptr_q];
  assign out_last  = (state_q == ST_DRAIN) && (rd_ptr_q == c_LAST_PTR);
  assign busy      = (state_q == ST_SORT) || (state_q == ST_DUPS);
  assign dup_count = dup_q;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    swapped_d = swapped_q;
    dup_d     = dup_q;
    case (state_q)
      ST_LOAD: begin
        if (load_wr) begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (wr_ptr_q == '0) dup_d = '0;
          if (wr_ptr_q == c_LAST_PTR) begin
            state_d   = ST_SORT;
            wr_ptr_d  = '0;
            idx_d     = '0;
            pass_d    = '0;
            swapped_d = 1'b0;
          end
        end
      end
      ST_SORT: begin
        if (cmp_out) swapped_d = 1'b1;
        if (idx_q == c_LAST_IDX) begin
          idx_d     = '0;
          pass_d    = pass_q + PTR_W'(1);
          swapped_d = 1'b0;
          // Done when this pass made no swap or DEPTH-1 passes are complete.
          if (!(swapped_q || cmp_out) || (pass_q == c_LAST_IDX)) begin
            state_d = ST_DUPS;
          end
        end else begin
          idx_d = idx_nxt;
        end
      end
      ST_DUPS: begin
        if (cmp_out) dup_d = dup_q + PTR_W'(1);
        if (idx_q == c_LAST_IDX) begin
          idx_d    = '0;
          rd_ptr_d = '0;
          state_d  = ST_DRAIN;
        end else begin
          idx_d = idx_nxt;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (rd_ptr_q == c_LAST_PTR) begin
            rd_ptr_d = '0;
            state_d  = ST_LOAD;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_LOAD;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      idx_q     <= '0;
      pass_q    <= '0;
      swapped_q <= 1'b0;
      dup_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      swapped_q <= swapped_d;
      dup_q     <= dup_d;
    end
  end

  // Storage is deliberately not reset; it is always refilled before use.
  always_ff @(posedge clk) begin
    if (load_wr) begin
      mem_q[wr_ptr_q] <= in_data;
    end else if (do_swap) begin
      mem_q[idx_q]   <= mem_q[idx_nxt];
      mem_q[idx_nxt] <= mem_q[idx_q];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_compare_sort_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_compare_sort_ctrl
//  Purpose  : Self-checking bench for compare_sort_ctrl (INPUT_SIZE=4,
//             DEPTH=8). Directed and random frames checked against a
//             reference model: sorted order, duplicate-pair count and
//             input-to-output latency derived from the inversion structure.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_compare_sort_ctrl;
  localparam int W = 4;
  localparam int D = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_ready = 1'b1;
  logic          in_ready, out_valid, out_last, busy;
  logic [W-1:0]  out_data;
  logic [$clog2(D)-1:0] dup_count;

  compare_sort_ctrl #(.INPUT_SIZE(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .dup_count (dup_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] frame [D];
  int exp_q[$];
  int exp_dups;
  int exp_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: sorted copy, equal neighbours, and bubble-pass count.
  // Bubble sort needs as many swapping passes as the largest number of
  // larger elements preceding any element, plus one clean pass, capped at D-1.
  task automatic build_model();
    int k, cnt, passes;
    exp_q.delete();
    for (int i = 0; i < D; i++) exp_q.push_back(int'(frame[i]));
    exp_q.sort();
    exp_dups = 0;
    for (int i = 0; i < D - 1; i++) if (exp_q[i] == exp_q[i+1]) exp_dups++;
    k = 0;
    for (int i = 0; i < D; i++) begin
      cnt = 0;
      for (int j = 0; j < i; j++) if (frame[j] > frame[i]) cnt++;
      if (cnt > k) k = cnt;
    end
    passes  = (k + 1 < D - 1) ? k + 1 : D - 1;
    exp_lat = (D - 1) * passes + (D - 1);
  endtask

  task automatic load_frame();
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      check("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      in_data  = frame[i];
      @(posedge clk);
      #1;
      if (i == 0) check("dup_clear", dup_count, 0);
    end
    in_valid = 1'b0;
  endtask

  // Keeps in_valid asserted with junk data while the block is busy.
  task automatic wait_output();
    int cyc = 0;
    @(negedge clk);
    check("busy_sort", busy, 1);
    check("in_ready_busy", in_ready, 0);
    in_valid = 1'b1;
    in_data  = W'($urandom);
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("latency", cyc, exp_lat);
    check("busy_drain", busy, 0);
  endtask

  task automatic drain(input bit stall);
    for (int k = 0; k < D; k++) begin
      if (stall && k == 3) begin
        out_ready = 1'b0;
        repeat (3) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, exp_q[3]);
          check("stall_in_ready", in_ready, 0);
          @(posedge clk);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      check("out_valid", out_valid, 1);
      check("out_data", out_data, exp_q[k]);
      check("out_last", out_last, (k == D - 1) ? 1 : 0);
      check("dup_count", dup_count, exp_dups);
      @(posedge clk);
      @(negedge clk);
    end
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("dup_hold", dup_count, exp_dups);
  endtask

  task automatic run_frame(input bit stall);
    build_model();
    load_frame();
    wait_output();
    drain(stall);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_dup", dup_count, 0);
    check("rst_last", out_last, 0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1);

    frame = '{4'd7, 4'd3, 4'd5, 4'd1, 4'd6, 4'd2, 4'd4, 4'd0};
    run_frame(1'b0);
    frame = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    run_frame(1'b0);
    frame = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    run_frame(1'b0);
    frame = '{4'd5, 4'd5, 4'd5, 4'd2, 4'd2, 4'd9, 4'd0, 4'd9};
    run_frame(1'b0);
    frame = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
    run_frame(1'b0);
    frame = '{4'd7, 4'd3, 4'd5, 4'd1, 4'd6, 4'd2, 4'd4, 4'd0};
    run_frame(1'b1);

    // Reset in the middle of sorting; the frame must vanish.
    frame = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2};
    load_frame();
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_dup", dup_count, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_rel_ready", in_ready, 1);
    check("midrst_rel_valid", out_valid, 0);
    frame = '{4'd7, 4'd3, 4'd5, 4'd1, 4'd6, 4'd2, 4'd4, 4'd0};
    run_frame(1'b0);

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < D; i++)
        frame[i] = (f < 3) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 3));
      run_frame(f == 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
